// File: rtl/gpgpu_iss_pkg.sv
// Shared constants and helpers for the GPGPU issue-stage arbiter.
// The index helpers cover requester vectors of up to ONEHOT_MAX_W entries.
package gpgpu_iss_pkg;

    localparam int unsigned NUM_OC_DEFAULT = 4;
    localparam int unsigned ONEHOT_MAX_W   = 32;
    localparam int unsigned IDX_MAX_W      = $clog2(ONEHOT_MAX_W);

    // The reset pointer sits on the top entry, so entry 0 wins the first arbitration.
    function automatic logic [ONEHOT_MAX_W-1:0] rst_ptr(input int unsigned n);
        return ONEHOT_MAX_W'(1) << (n - 1);
    endfunction

    function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [ONEHOT_MAX_W-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (oh[i]) idx = idx | IDX_MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector to start just above the pointer,
// take the lowest set bit, then rotate the one-hot result back.
module rr_pick
    import gpgpu_iss_pkg::*;
#(
    parameter  int unsigned N     = NUM_OC_DEFAULT,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_ptr,
    output logic [N-1:0] o_pick
);

    logic [IDX_W-1:0] w_ptr_idx;
    logic [IDX_W-1:0] w_start;
    logic [N-1:0]     w_req_rot;
    logic [N-1:0]     w_pick_rot;

    assign w_ptr_idx = IDX_W'(onehot2idx(ONEHOT_MAX_W'(i_ptr)));
    assign w_start   = (w_ptr_idx == IDX_W'(N - 1)) ? '0 : w_ptr_idx + IDX_W'(1);

    assign w_req_rot  = N'({i_req, i_req} >> w_start);
    assign w_pick_rot = w_req_rot & (~w_req_rot + N'(1));
    assign o_pick     = N'({w_pick_rot, w_pick_rot} >> (N - 32'(w_start)));

endmodule

// File: rtl/ex_issue_arbiter.sv
// Registered round-robin issue arbiter between the OC entries and one EX pipe, with
// writeback-steal rollback and EX back-pressure. Define ISS_AGE_BOOST_EN for starvation boost.
module ex_issue_arbiter
    import gpgpu_iss_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = NUM_OC_DEFAULT,
    parameter  int unsigned MAX_WAIT = 15,
    localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] oc_iss_req,
    input  logic               ex_ready,
    input  logic               mshr_done,
    output logic [NUM_REQ-1:0] ex_iu_grant,
    output logic               ex_iu_grant_vld,
    output logic [IDX_W-1:0]   ex_iu_grant_idx
);

    localparam logic [NUM_REQ-1:0] PTR_RST = NUM_REQ'(rst_ptr(NUM_REQ));
    localparam int unsigned        CNT_W   = $clog2(MAX_WAIT + 1);

    logic [NUM_REQ-1:0] r_grant_raw;
    logic [NUM_REQ-1:0] r_ptr;
    logic [NUM_REQ-1:0] r_ptr_prev;
    logic [NUM_REQ-1:0] w_masked_req;
    logic [NUM_REQ-1:0] w_ptr_eff;
    logic [NUM_REQ-1:0] w_rr_pick;
    logic [NUM_REQ-1:0] w_pick;

    // A stolen writeback slot kills the presented grant; the entry stays unmasked and re-arbitrates.
    assign ex_iu_grant     = r_grant_raw & {NUM_REQ{~mshr_done}};
    assign ex_iu_grant_vld = |ex_iu_grant;
    assign ex_iu_grant_idx = IDX_W'(onehot2idx(ONEHOT_MAX_W'(ex_iu_grant)));

    assign w_masked_req = oc_iss_req & ~ex_iu_grant;
    assign w_ptr_eff    = mshr_done ? r_ptr_prev : r_ptr;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .i_req  (w_masked_req),
        .i_ptr  (w_ptr_eff),
        .o_pick (w_rr_pick)
    );

`ifdef ISS_AGE_BOOST_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] r_wait;
    logic [NUM_REQ-1:0]            w_starved;
    logic [NUM_REQ-1:0]            w_boost_pick;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_starved[i] = w_masked_req[i] && (r_wait[i] == CNT_W'(MAX_WAIT));
        end
    end

    assign w_boost_pick = w_starved & (~w_starved + NUM_REQ'(1));
    assign w_pick       = !ex_ready ? '0 : ((|w_starved) ? w_boost_pick : w_rr_pick);

    // NOTE: the wait counters feed the pick directly, so they are reset like any control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!oc_iss_req[i] || ex_iu_grant[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != CNT_W'(MAX_WAIT)) begin
                    r_wait[i] <= r_wait[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    // MAX_WAIT only matters with the boost; it is tied off in the plain round-robin build.
    logic [CNT_W-1:0] w_unused_max_wait;
    assign w_unused_max_wait = CNT_W'(MAX_WAIT);
    assign w_pick            = ex_ready ? w_rr_pick : '0;
`endif

    // NOTE: non-blocking assignments keep ptr and ptr_prev updating as one atomic pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_raw <= '0;
            r_ptr       <= PTR_RST;
            r_ptr_prev  <= PTR_RST;
        end else begin
            r_grant_raw <= w_pick;
            r_ptr       <= (|w_pick) ? w_pick : w_ptr_eff;
            r_ptr_prev  <= w_ptr_eff;
        end
    end

endmodule

// File: tb/tb_ex_issue_arbiter.sv
// Directed bench for ex_issue_arbiter: per-scenario vector tables with hand-computed grants.
// Row k of each table holds the inputs and expected outputs of cycle k after reset release.
module tb_ex_issue_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] oc_iss_req;
    logic       ex_ready;
    logic       mshr_done;
    logic [3:0] ex_iu_grant;
    logic       ex_iu_grant_vld;
    logic [1:0] ex_iu_grant_idx;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic       mshr;
        logic [3:0] g;
        logic [1:0] idx;
    } vec_t;

    ex_issue_arbiter #(
        .NUM_REQ  (4),
        .MAX_WAIT (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .oc_iss_req      (oc_iss_req),
        .ex_ready        (ex_ready),
        .mshr_done       (mshr_done),
        .ex_iu_grant     (ex_iu_grant),
        .ex_iu_grant_vld (ex_iu_grant_vld),
        .ex_iu_grant_idx (ex_iu_grant_idx)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] req, input logic rdy, input logic mshr,
                                input logic [3:0] g, input logic [1:0] idx);
        vec_t v;
        v.req  = req;
        v.rdy  = rdy;
        v.mshr = mshr;
        v.g    = g;
        v.idx  = idx;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic rdy, input logic mshr);
        oc_iss_req = req;
        ex_ready   = rdy;
        mshr_done  = mshr;
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        oc_iss_req = '0;
        ex_ready   = 1'b0;
        mshr_done  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        oc_iss_req = 4'b1111;
        ex_ready   = 1'b1;
        mshr_done  = 1'b0;
        #1;
        n_checks++;
        if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_async: got grant=%b vld=%b idx=%0d, expected all zero",
                     ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx);
        end
        cyc();
        n_checks++;
        if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_held: got grant=%b vld=%b idx=%0d, expected all zero",
                     ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx);
        end
    endtask

    task automatic test_round_robin();
        vec_t v [6];
        v[0] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        v[2] = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1);
        v[3] = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2);
        v[4] = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3);
        v[5] = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL round_robin row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            cyc();
        end
    endtask

    task automatic test_mshr_cancel();
        vec_t v [6];
        v[0] = mk(4'b0101, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b0101, 1'b1, 1'b0, 4'b0001, 2'd0);
        v[2] = mk(4'b0101, 1'b1, 1'b1, 4'b0000, 2'd0);
        v[3] = mk(4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2);
        v[4] = mk(4'b0101, 1'b1, 1'b0, 4'b0001, 2'd0);
        v[5] = mk(4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL mshr_cancel row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            cyc();
        end
    endtask

    task automatic test_mshr_hold();
        vec_t v [6];
        v[0] = mk(4'b0110, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1);
        v[2] = mk(4'b0110, 1'b1, 1'b1, 4'b0000, 2'd0);
        v[3] = mk(4'b0110, 1'b1, 1'b1, 4'b0000, 2'd0);
        v[4] = mk(4'b0110, 1'b1, 1'b0, 4'b0100, 2'd2);
        v[5] = mk(4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL mshr_hold row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            if (k == 4) begin
                n_checks++;
                if (dut.r_ptr !== 4'b0100) begin
                    n_errors++;
                    $display("FAIL mshr_hold_ptr: got ptr=%b, expected ptr=0100", dut.r_ptr);
                end
            end
            cyc();
        end
    endtask

    task automatic test_ex_ready();
        vec_t v [8];
        v[0] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        v[2] = mk(4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1);
        v[3] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0);
        v[4] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0);
        v[5] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[6] = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2);
        v[7] = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL ex_ready row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            cyc();
        end
    endtask

    task automatic test_req_drop();
        vec_t v [4];
        v[0] = mk(4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);
        v[2] = mk(4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1);
        v[3] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL req_drop row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            cyc();
        end
    endtask

    task automatic test_idle_mshr();
        vec_t v [10];
        v[0] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        v[2] = mk(4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1);
        v[3] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0);
        v[4] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[5] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0);
        v[6] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0);
        v[7] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[8] = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2);
        v[9] = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL idle_mshr row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'b1111, 1'b1, 1'b0);
        cyc();
        cyc();
        n_checks++;
        if (ex_iu_grant !== 4'b0010) begin
            n_errors++;
            $display("FAIL reset_mid_pre: got grant=%b, expected grant=0010", ex_iu_grant);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_mid_async: got grant=%b vld=%b idx=%0d, expected all zero",
                     ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx);
        end
        n_checks++;
        if (dut.r_ptr !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_mid_ptr: got ptr=%b, expected ptr=1000", dut.r_ptr);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(4'b1111, 1'b1, 1'b0);
        cyc();
        n_checks++;
        if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {4'b0001, 1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_mid_first: got grant=%b vld=%b idx=%0d, expected grant=0001 vld=1 idx=0",
                     ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx);
        end
    endtask

`ifdef ISS_AGE_BOOST_EN
    task automatic test_age_boost();
        vec_t v [6];
        v[0] = mk(4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0);
        v[1] = mk(4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0);
        v[2] = mk(4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0);
        v[3] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
        v[4] = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3);
        v[5] = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(v[k].req, v[k].rdy, v[k].mshr);
            n_checks++;
            if ({ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx} !== {v[k].g, |v[k].g, v[k].idx}) begin
                n_errors++;
                $display("FAIL age_boost row%0d: got grant=%b vld=%b idx=%0d, expected grant=%b vld=%b idx=%0d",
                         k, ex_iu_grant, ex_iu_grant_vld, ex_iu_grant_idx, v[k].g, |v[k].g, v[k].idx);
            end
            if (k == 3 || k == 5) begin
                n_checks++;
                if (dut.r_wait[3] !== ((k == 3) ? 2'd3 : 2'd0)) begin
                    n_errors++;
                    $display("FAIL age_boost_cnt row%0d: got wait=%0d, expected wait=%0d",
                             k, dut.r_wait[3], (k == 3) ? 3 : 0);
                end
            end
            cyc();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_mshr_cancel();
        test_mshr_hold();
        test_ex_ready();
        test_req_drop();
        test_idle_mshr();
        test_reset_mid();
`ifdef ISS_AGE_BOOST_EN
        test_age_boost();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
